// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver core and the register interface.
// Optional watermark flag on level_irq is enabled by defining UART_RX_FIFO_WATERMARK_EN.
module uart_rx_fifo #(
  parameter  int DATA_W    = 8,
  parameter  int DEPTH     = 16,
  parameter  int WATERMARK = 8,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              clr_overrun,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  output logic              level_irq
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end
  if ((WATERMARK < 1) || (WATERMARK > DEPTH)) begin : g_bad_watermark
    $error("uart_rx_fifo: WATERMARK must lie in 1..DEPTH");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              push_ok;
  logic              pop_ok;
  logic              drop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is still taken.
  always_comb begin
    pop_ok    = rd_en && !flush && !empty;
    push_ok   = wr_valid && !flush && (!full || pop_ok);
    drop      = wr_valid && !flush && !push_ok;
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push_ok && !pop_ok)
      count_nxt = count + ONE;
    else if (pop_ok && !push_ok)
      count_nxt = count - ONE;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      count    <= count_nxt;
      empty    <= (count_nxt == '0);
      full     <= (count_nxt == CNT_FULL);
      rd_valid <= pop_ok;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok)
          wr_ptr <= wr_ptr + ONE;
        if (pop_ok) begin
          rd_ptr  <= rd_ptr + ONE;
          rd_data <= mem[rd_ptr[ADDR_W-1:0]];
        end
      end
      // A drop coinciding with a clear keeps the flag set.
      if (drop)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_WATERMARK_EN
  localparam logic [ADDR_W:0] CNT_WM = (ADDR_W+1)'(WATERMARK);

  always_ff @(posedge clk) begin
    if (!rst)
      level_irq <= 1'b0;
    else
      level_irq <= (count_nxt >= CNT_WM);
  end
`else
  assign level_irq = 1'b0;
`endif

endmodule
